// File: rtl/nibble_add_sched.sv
// nibble_add_sched: shares one 4-bit adder between two requesters for wide adds, LSB nibble first.
// Define NIBBLE_SCHED_FIXED_PRIO_EN for fixed req0-first priority instead of round-robin.
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id,
  output logic                 busy
);
  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r, sum_r;
  logic carry_r, id_r, g0, g1, accept;
  logic [3:0] idx;
  logic [4:0] nib;
`ifdef NIBBLE_SCHED_FIXED_PRIO_EN
  assign g0 = req0_valid;
`else
  logic last_grant;
  assign g0 = req0_valid & (~req1_valid | last_grant);
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= req1_ready;
`endif
  assign g1 = req1_valid & ~g0;
  assign req0_ready = (state == IDLE) & ~rst & g0;
  assign req1_ready = (state == IDLE) & ~rst & g1;
  assign accept = req0_ready | req1_ready;
  assign nib = 5'(a_r[3:0]) + 5'(b_r[3:0]) + 5'(carry_r);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (accept ? RUN : IDLE)
            : (state == RUN)  ? ((idx == LAST) ? DONE : RUN)
            : (res_ready ? IDLE : DONE);
  end
  // operands shift down so the active nibble is always [3:0]; sum fills from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      id_r    <= 1'b0;
      idx     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r     <= req1_ready ? req1_a : req0_a;
        b_r     <= req1_ready ? req1_b : req0_b;
        carry_r <= req1_ready ? req1_cin : req0_cin;
        id_r    <= req1_ready;
        sum_r   <= '0;
        idx     <= '0;
      end else if (state == RUN) begin
        a_r     <= a_r >> 4;
        b_r     <= b_r >> 4;
        sum_r   <= W'({nib[3:0], sum_r} >> 4);
        carry_r <= nib[4];
        idx     <= idx + 4'd1;
      end
    end
  end
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_sum   = sum_r;
  assign res_cout  = carry_r;
  assign res_id    = id_r;
endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: directed and random checks of nibble_add_sched against a behavioural model.
module tb_nibble_add_sched;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 1'b0, rst = 1'b0;
  logic req0_valid = 1'b0, req0_ready, req0_cin = 1'b0;
  logic req1_valid = 1'b0, req1_ready, req1_cin = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic res_valid, res_ready = 1'b0, res_cout, res_id, busy;
  logic [W-1:0] res_sum;
  int n_cmp = 0, n_bad = 0;

  typedef struct { logic id; logic [W:0] total; } exp_t;
  exp_t q[$];

  nibble_add_sched #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cout", res_cout, 0);
    chk("rst_id", res_id, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 40) begin
      chk("run_ready0", req0_ready, 0);
      chk("run_ready1", req1_ready, 0);
      chk("run_busy", busy, 1);
      tick();
      cyc++;
    end
  endtask

  task automatic op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] e;
    int cyc;
    e = add(a, b, c);
    if (id) begin req1_a = a; req1_b = b; req1_cin = c; end
    else begin req0_a = a; req0_b = b; req0_cin = c; end
    req0_valid = !id;
    req1_valid = id;
    #1;
    chk("op_ready", id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_result(cyc);
    chk("op_latency", cyc, N);
    chk("op_sum", res_sum, e[W-1:0]);
    chk("op_cout", res_cout, e[W]);
    chk("op_id", res_id, id);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("op_release", res_valid, 0);
    chk("op_idle", busy, 0);
  endtask

  initial begin
    logic [W:0] e;
    logic [W-1:0] oa [2], ob [2];
    logic oc [2];
    int cyc, done_cnt, acc_cnt, m_run, m_last;
    logic m_done, idle, x0, x1;
    exp_t t;

    do_reset();
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    op(1'b1, 16'h0F0F, 16'h00F1, 1'b1);

    // both requesters valid continuously from reset
    do_reset();
    oa[0] = 16'h1111; ob[0] = 16'h2222; oc[0] = 1'b0;
    oa[1] = 16'hABCD; ob[1] = 16'h7777; oc[1] = 1'b1;
    req0_a = oa[0]; req0_b = ob[0]; req0_cin = oc[0];
    req1_a = oa[1]; req1_b = ob[1]; req1_cin = oc[1];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int g;
`ifdef NIBBLE_SCHED_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      #1;
      chk("alt_ready0", req0_ready, g == 0);
      chk("alt_ready1", req1_ready, g == 1);
      tick();
      wait_result(cyc);
      e = add(oa[g], ob[g], oc[g]);
      chk("alt_latency", cyc, N);
      chk("alt_id", res_id, g);
      chk("alt_sum", res_sum, e[W-1:0]);
      chk("alt_cout", res_cout, e[W]);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // backpressure while the other requester waits
    req1_a = 16'h8000; req1_b = 16'h9001; req1_cin = 1'b1;
    e = add(16'h8000, 16'h9001, 1'b1);
    req1_valid = 1'b1;
    #1;
    chk("bp_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    wait_result(cyc);
    chk("bp_latency", cyc, N);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", res_sum, e[W-1:0]);
      chk("bp_cout", res_cout, e[W]);
      chk("bp_ready0", req0_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_taken", res_valid, 0);
    chk("bp_next_ready", req0_ready, 1);
    req0_valid = 1'b0;
    tick();

    // reset during nibble 2 discards the op
    req1_a = 16'h1234; req1_b = 16'h4321; req1_cin = 1'b1;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_valid", res_valid, 0);
    chk("abort_sum", res_sum, 0);
    chk("abort_cout", res_cout, 0);
    chk("abort_id", res_id, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    op(1'b0, 16'h1234, 16'h4321, 1'b0);

    // random sweep against a transaction-level model
    do_reset();
    m_last = 1; m_run = 0; m_done = 1'b0; done_cnt = 0; acc_cnt = 0; cyc = 0;
    while (done_cnt < 200 && cyc < 20000) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      idle = (m_run == 0) && !m_done;
`ifdef NIBBLE_SCHED_FIXED_PRIO_EN
      x0 = idle && req0_valid;
`else
      x0 = idle && req0_valid && (!req1_valid || m_last == 1);
`endif
      x1 = idle && req1_valid && !x0;
      chk("rnd_ready0", req0_ready, x0);
      chk("rnd_ready1", req1_ready, x1);
      chk("rnd_valid", res_valid, m_done);
      if (m_done && res_ready) begin
        if (q.size() == 0) chk("rnd_queue", 0, 1);
        else begin
          t = q.pop_front();
          chk("rnd_sum", res_sum, t.total[W-1:0]);
          chk("rnd_cout", res_cout, t.total[W]);
          chk("rnd_id", res_id, t.id);
        end
        m_done = 1'b0;
        done_cnt++;
      end else if (m_run > 0) begin
        m_run--;
        if (m_run == 0) m_done = 1'b1;
      end else if (x0 || x1) begin
        t.id = x1;
        t.total = x1 ? add(req1_a, req1_b, req1_cin) : add(req0_a, req0_b, req0_cin);
        q.push_back(t);
        m_last = x1 ? 1 : 0;
        m_run = N;
        acc_cnt++;
      end
      tick();
      cyc++;
    end
    chk("rnd_done", done_cnt, 200);
    chk("rnd_accepted", acc_cnt, 200);
    chk("rnd_leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
